// File: rtl/fp8_mac_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : fp8_mac_stream_if
// Purpose  : Operand/result stream bundle for fp8_mac_stream.
// Revision : 1.0 - initial release
// ============================================================================
interface fp8_mac_stream_if #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3,
  parameter int ACC_W = 48,
  parameter int CNT_W = 8
);
  localparam int c_OP_W = 1 + EXP_W + MAN_W;

  logic              in_valid;
  logic              in_ready;
  logic [c_OP_W-1:0] in_a;
  logic [c_OP_W-1:0] in_b;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic              out_sat;
  logic [CNT_W-1:0]  out_count;
  logic [c_OP_W-1:0] out_fp8;

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_sat, out_count, out_fp8
  );

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_sat, out_count, out_fp8
  );
endinterface
`default_nettype wire

// File: rtl/fp8_mac_stream.sv
`default_nettype none
// ============================================================================
// Module   : fp8_mac_stream
// Purpose  : Streaming minifloat MAC, exact fixed-point accumulation per vector.
//            Optional rounded minifloat result: FP8_MAC_ROUND_OUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fp8_mac_stream #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3,
  parameter int ACC_W = 48,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  fp8_mac_stream_if.slave s
);
  localparam int c_MAG_W = 2 * (MAN_W + 1);
  localparam int c_SH_W  = EXP_W + 1;
  localparam logic [ACC_W-1:0] c_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] c_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  state_t r_state, w_next;
  logic   w_in_ready, w_accept, w_load, w_clear;

  // Operand decode: exp==0 is subnormal with hidden bit 0 and effective exp 1
  logic [EXP_W-1:0]   w_ea, w_eb;
  logic [MAN_W:0]     w_ma, w_mb;
  logic [c_MAG_W-1:0] w_prod;
  logic [c_SH_W-1:0]  w_sh;

  assign w_ea   = (s.in_a[MAN_W +: EXP_W] == '0) ? EXP_W'(1) : s.in_a[MAN_W +: EXP_W];
  assign w_eb   = (s.in_b[MAN_W +: EXP_W] == '0) ? EXP_W'(1) : s.in_b[MAN_W +: EXP_W];
  assign w_ma   = {|s.in_a[MAN_W +: EXP_W], s.in_a[MAN_W-1:0]};
  assign w_mb   = {|s.in_b[MAN_W +: EXP_W], s.in_b[MAN_W-1:0]};
  assign w_prod = c_MAG_W'(w_ma) * c_MAG_W'(w_mb);
  assign w_sh   = c_SH_W'(w_ea) + c_SH_W'(w_eb) - c_SH_W'(2);

  assign w_accept = s.in_valid & w_in_ready;

  logic               r_s1_valid, r_s1_sign, r_s1_last;
  logic [c_MAG_W-1:0] r_s1_mag;
  logic [c_SH_W-1:0]  r_s1_sh;
  logic               r_s2_valid, r_s2_last;
  logic [ACC_W-1:0]   r_s2_add;
  logic               r_s3_last;
  logic [ACC_W-1:0]   r_acc;
  logic               r_sat;
  logic [CNT_W-1:0]   r_cnt;

  logic [ACC_W-1:0]   w_add_mag;
  logic [ACC_W:0]     w_sum;
  logic               w_ovf;

  assign w_add_mag = ACC_W'(r_s1_mag) << r_s1_sh;
  assign w_sum     = {r_acc[ACC_W-1], r_acc} + {r_s2_add[ACC_W-1], r_s2_add};
  assign w_ovf     = w_sum[ACC_W] ^ w_sum[ACC_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_mag   <= '0;
      r_s1_sh    <= '0;
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_add   <= '0;
      r_s3_last  <= 1'b0;
      r_acc      <= '0;
      r_sat      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_sign <= s.in_a[EXP_W+MAN_W] ^ s.in_b[EXP_W+MAN_W];
        r_s1_mag  <= w_prod;
        r_s1_sh   <= w_sh;
        r_s1_last <= s.in_last;
      end
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_valid & r_s1_last;
      r_s2_add   <= r_s1_sign ? -w_add_mag : w_add_mag;
      r_s3_last  <= r_s2_valid & r_s2_last;
      if (w_clear) begin
        r_acc <= '0;
        r_sat <= 1'b0;
      end else if (r_s2_valid) begin
        r_acc <= w_ovf ? (w_sum[ACC_W] ? c_ACC_MIN : c_ACC_MAX) : w_sum[ACC_W-1:0];
        r_sat <= r_sat | w_ovf;
      end
      if (w_clear)
        r_cnt <= '0;
      else if (w_accept && (r_cnt != '1))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_ACCUM;
    else
      r_state <= w_next;
  end

  // DRAIN ends when the carried last flag leaves S3, i.e. 3 cycles after acceptance
  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_load     = 1'b0;
    w_clear    = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        w_in_ready = 1'b1;
        if (w_accept && s.in_last)
          w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_s3_last) begin
          w_load = 1'b1;
          w_next = ST_OUT;
        end
      end
      ST_OUT: begin
        if (s.out_ready) begin
          w_clear = 1'b1;
          w_next  = ST_ACCUM;
        end
      end
      default: w_next = ST_ACCUM;
    endcase
  end

  logic             r_out_valid, r_out_sat;
  logic [ACC_W-1:0] r_out_acc;
  logic [CNT_W-1:0] r_out_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_sat   <= 1'b0;
      r_out_acc   <= '0;
      r_out_cnt   <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_sat   <= r_sat;
      r_out_acc   <= r_acc;
      r_out_cnt   <= r_cnt;
    end else if (w_clear) begin
      r_out_valid <= 1'b0;
    end
  end

  assign s.in_ready  = w_in_ready;
  assign s.out_valid = r_out_valid;
  assign s.out_acc   = r_out_acc;
  assign s.out_sat   = r_out_sat;
  assign s.out_count = r_out_cnt;

`ifdef FP8_MAC_ROUND_OUT_EN
  localparam int c_OP_W = 1 + EXP_W + MAN_W;
  localparam int c_BIAS = (1 << (EXP_W - 1)) - 1;
  // Accumulator LSB position of the mantissa LSB for exponent field 0
  localparam int c_OFF  = c_BIAS - 2 + MAN_W;
  localparam int c_MAXC = (1 << (EXP_W + MAN_W)) - 1;

  logic              w_neg, w_g, w_st, w_inc;
  logic [ACC_W-1:0]  w_mag, w_q, w_code;
  int                w_lod, w_s;
  logic [c_OP_W-1:0] w_fp8, r_out_fp8;

  // Code = ((shift - c_OFF - 1) << MAN_W) + rounded mantissa; carries ripple into exponent
  always_comb begin
    w_neg = r_acc[ACC_W-1];
    w_mag = w_neg ? -r_acc : r_acc;
    w_lod = 0;
    for (int i = 0; i < ACC_W; i++)
      if (w_mag[i]) w_lod = i;
    w_s    = (w_lod - MAN_W > c_OFF + 1) ? (w_lod - MAN_W) : (c_OFF + 1);
    w_q    = w_mag >> w_s;
    w_g    = |(w_mag & (ACC_W'(1) << (w_s - 1)));
    w_st   = |(w_mag << (ACC_W - w_s + 1));
    w_inc  = w_g & (w_st | w_q[0]);
    w_code = ACC_W'((w_s - c_OFF - 1) << MAN_W) + w_q + ACC_W'(w_inc);
    if (r_sat || (w_code > ACC_W'(c_MAXC)))
      w_fp8 = {w_neg, {(EXP_W+MAN_W){1'b1}}};
    else
      w_fp8 = {w_neg, w_code[EXP_W+MAN_W-1:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_out_fp8 <= '0;
    else if (w_load)
      r_out_fp8 <= w_fp8;
  end

  assign s.out_fp8 = r_out_fp8;
`else
  assign s.out_fp8 = '0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_fp8_mac_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp8_mac_stream
// Purpose  : Directed self-checking bench for fp8_mac_stream (48- and 40-bit acc).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp8_mac_stream;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp8_mac_stream_if #(.EXP_W(4), .MAN_W(3), .ACC_W(48), .CNT_W(8)) bus ();
  fp8_mac_stream_if #(.EXP_W(4), .MAN_W(3), .ACC_W(40), .CNT_W(8)) bus40 ();

  fp8_mac_stream #(.EXP_W(4), .MAN_W(3), .ACC_W(48), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .s(bus.slave));
  fp8_mac_stream #(.EXP_W(4), .MAN_W(3), .ACC_W(40), .CNT_W(8)) dut40 (
    .clk(clk), .rst_n(rst_n), .s(bus40.slave));

`ifdef FP8_MAC_ROUND_OUT_EN
  localparam bit c_RND = 1'b1;
`else
  localparam bit c_RND = 1'b0;
`endif

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int lat;
  bit stable;

  function automatic logic [7:0] fx(input logic [7:0] v);
    return c_RND ? v : 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic l);
    if (sel) begin
      bus40.in_valid = v; bus40.in_a = a; bus40.in_b = b; bus40.in_last = l;
    end else begin
      bus.in_valid = v; bus.in_a = a; bus.in_b = b; bus.in_last = l;
    end
  endtask

  task automatic beat(input bit sel, input logic [7:0] a, input logic [7:0] b, input logic l);
    drive(sel, 1'b1, a, b, l);
    step();
    drive(sel, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic wait_out(input bit sel, output int n);
    n = 0;
    while (!(sel ? bus40.out_valid : bus.out_valid) && n < 50) begin
      step();
      n++;
    end
  endtask

  task automatic take(input bit sel);
    if (sel) bus40.out_ready = 1'b1; else bus.out_ready = 1'b1;
    step();
    if (sel) bus40.out_ready = 1'b0; else bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    bus.out_ready   = 1'b0;
    bus40.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_acc", bus.out_acc, 0);
    chk("rst_out_count", bus.out_count, 0);
    chk("rst_out_sat", bus.out_sat, 0);
    chk("rst_out_fp8", bus.out_fp8, 0);

    // 1.0 * 1.0, single-beat vector
    beat(1'b0, 8'h38, 8'h38, 1'b1);
    wait_out(1'b0, lat);
    chk("one_latency", lat, 3);
    chk("one_acc", bus.out_acc, 64'h40000);
    chk("one_count", bus.out_count, 1);
    chk("one_sat", bus.out_sat, 0);
    chk("one_fp8", bus.out_fp8, fx(8'h38));
    chk("one_in_ready_out", bus.in_ready, 0);
    take(1'b0);
    chk("one_in_ready_after", bus.in_ready, 1);

    // 2.0 - 1.0 + 2^-18
    beat(1'b0, 8'h40, 8'h38, 1'b0);
    beat(1'b0, 8'hB8, 8'h38, 1'b0);
    beat(1'b0, 8'h01, 8'h01, 1'b1);
    wait_out(1'b0, lat);
    chk("mix_latency", lat, 3);
    chk("mix_acc", bus.out_acc, 64'h40001);
    chk("mix_count", bus.out_count, 3);
    chk("mix_fp8", bus.out_fp8, fx(8'h38));
    take(1'b0);

    // -1.0
    beat(1'b0, 8'hB8, 8'h38, 1'b1);
    wait_out(1'b0, lat);
    chk("neg_acc", bus.out_acc, 64'hFFFF_FFFC_0000);
    chk("neg_fp8", bus.out_fp8, fx(8'hB8));
    take(1'b0);

    // -2^-18: below half the smallest subnormal, rounds to -0
    beat(1'b0, 8'h81, 8'h01, 1'b1);
    wait_out(1'b0, lat);
    chk("tiny_acc", bus.out_acc, 64'hFFFF_FFFF_FFFF);
    chk("tiny_fp8", bus.out_fp8, fx(8'h80));
    take(1'b0);

    // Max product with input gaps carrying junk data, then a held-off result
    drive(1'b0, 1'b0, 8'h7F, 8'h7F, 1'b0);
    repeat (2) step();
    beat(1'b0, 8'h7F, 8'h7F, 1'b0);
    drive(1'b0, 1'b0, 8'h7F, 8'h7F, 1'b1);
    repeat (3) step();
    beat(1'b0, 8'h00, 8'h00, 1'b1);
    wait_out(1'b0, lat);
    chk("max_latency", lat, 3);
    chk("max_acc", bus.out_acc, 64'hE_1000_0000);
    chk("max_count", bus.out_count, 2);
    chk("max_fp8", bus.out_fp8, fx(8'h7F));
    stable = 1'b1;
    repeat (5) begin
      step();
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_acc !== 48'hE_1000_0000)
        stable = 1'b0;
    end
    chk("max_hold_stable", stable, 1);
    take(1'b0);
    chk("max_valid_cleared", bus.out_valid, 0);
    chk("max_in_ready_back", bus.in_ready, 1);

    // 40-bit accumulator: ten max products overflow
    for (int i = 0; i < 10; i++)
      beat(1'b1, 8'h7F, 8'h7F, (i == 9));
    wait_out(1'b1, lat);
    chk("sat_latency", lat, 3);
    chk("sat_acc", bus40.out_acc, 64'h7F_FFFF_FFFF);
    chk("sat_flag", bus40.out_sat, 1);
    chk("sat_count", bus40.out_count, 10);
    chk("sat_fp8", bus40.out_fp8, fx(8'h7F));
    take(1'b1);
    beat(1'b1, 8'h38, 8'h38, 1'b1);
    wait_out(1'b1, lat);
    chk("sat_next_flag", bus40.out_sat, 0);
    chk("sat_next_acc", bus40.out_acc, 64'h40000);
    take(1'b1);

    // Back-to-back vectors with in_valid never dropping
    bus.out_ready = 1'b1;
    drive(1'b0, 1'b1, 8'h40, 8'h38, 1'b1);
    step();
    drive(1'b0, 1'b1, 8'h38, 8'h38, 1'b1);
    wait_out(1'b0, lat);
    chk("b2b_first_latency", lat, 3);
    chk("b2b_first_acc", bus.out_acc, 64'h80000);
    chk("b2b_first_count", bus.out_count, 1);
    step();
    chk("b2b_in_ready", bus.in_ready, 1);
    chk("b2b_valid_cleared", bus.out_valid, 0);
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    wait_out(1'b0, lat);
    chk("b2b_second_latency", lat, 3);
    chk("b2b_second_acc", bus.out_acc, 64'h40000);
    chk("b2b_second_count", bus.out_count, 1);
    step();
    bus.out_ready = 1'b0;

    // Asynchronous reset in the middle of a vector
    beat(1'b0, 8'h38, 8'h38, 1'b0);
    beat(1'b0, 8'h38, 8'h38, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("arst_acc", bus.out_acc, 0);
    chk("arst_count", bus.out_count, 0);
    chk("arst_valid", bus.out_valid, 0);
    step();
    rst_n = 1'b1;
    step();
    beat(1'b0, 8'h38, 8'h38, 1'b1);
    wait_out(1'b0, lat);
    chk("arst_latency", lat, 3);
    chk("arst_fresh_acc", bus.out_acc, 64'h40000);
    chk("arst_fresh_count", bus.out_count, 1);
    take(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
